// File: rtl/mem_stage_if.sv
// Execute/memory/write-back handshake and data-SRAM response bundle for the MEM stage.
// slave is the stage's own view; master is the surrounding pipeline's view.
interface mem_stage_if;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [4:0]  es_dest;
  logic        es_rf_we;
  logic        es_mem_req;
  logic [2:0]  es_ld_op;
  logic [1:0]  es_addr_lo;
  logic [31:0] es_result;
  logic        es_ex;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic        ms_rf_we;
  logic [31:0] ms_result;
  logic        ms_ex;
  logic        ms_fwd_valid;
  logic        ms_fwd_stall;

  modport slave (
    input  es_to_ms_valid, es_pc, es_dest, es_rf_we, es_mem_req, es_ld_op,
           es_addr_lo, es_result, es_ex, data_sram_data_ok, data_sram_rdata,
           flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_rf_we, ms_result,
           ms_ex, ms_fwd_valid, ms_fwd_stall
  );

  modport master (
    output es_to_ms_valid, es_pc, es_dest, es_rf_we, es_mem_req, es_ld_op,
           es_addr_lo, es_result, es_ex, data_sram_data_ok, data_sram_rdata,
           flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_rf_we, ms_result,
           ms_ex, ms_fwd_valid, ms_fwd_stall
  );
endinterface

// File: rtl/mem_stage.sv
// LoongArch MEM stage: waits for data_ok, aligns/extends load data, forwards hazards,
// and discards responses belonging to requests orphaned by a flush.
module mem_stage #(
    parameter int unsigned DROP_CNT_W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    mem_stage_if.slave   bus
);

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_B    = 3'b001,
        LD_BU   = 3'b010,
        LD_H    = 3'b011,
        LD_HU   = 3'b100,
        LD_W    = 3'b101
    } ld_op_e;

    localparam int unsigned CW = DROP_CNT_W + 1;

    logic                  r_valid;
    logic                  r_have_data;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [31:0]           r_buf;
    logic [31:0]           r_pc;
    logic [4:0]            r_dest;
    logic                  r_rf_we;
    logic                  r_mem_req;
    ld_op_e                r_ld_op;
    logic [1:0]            r_addr_lo;
    logic [31:0]           r_result;
    logic                  r_ex;

    logic          w_live_ok;
    logic          w_stale;
    logic          w_ready_go;
    logic          w_allowin;
    logic          w_to_ws;
    logic          w_handoff;
    logic          w_waiting;
    logic          w_capture;
    logic          w_load;
    logic          w_orphan_a;
    logic          w_orphan_b;
    logic [CW-1:0] w_drop_sum;
    logic [31:0]   w_ld_data;
    logic [31:0]   w_shifted;
    logic [31:0]   w_final;
    logic          w_rf_we;
    logic          w_fwd_valid;

    // A nonzero drop count means the next response belongs to a flushed request.
    assign w_live_ok  = bus.data_sram_data_ok & (r_drop_cnt == '0);
    assign w_stale    = bus.data_sram_data_ok & (r_drop_cnt != '0);
    assign w_ready_go = ~r_mem_req | r_have_data | w_live_ok;
    assign w_allowin  = ~r_valid | (w_ready_go & bus.ws_allowin) | bus.flush;
    assign w_to_ws    = r_valid & w_ready_go & ~bus.flush;
    assign w_handoff  = w_to_ws & bus.ws_allowin;
    assign w_waiting  = r_valid & r_mem_req & ~r_have_data;
    assign w_capture  = w_live_ok & w_waiting & ~w_handoff & ~bus.flush;
    assign w_load     = bus.es_to_ms_valid & w_allowin & ~bus.flush;

    assign w_orphan_a = bus.flush & w_waiting & ~w_live_ok;
    assign w_orphan_b = bus.flush & bus.es_to_ms_valid & bus.es_mem_req;

    // Stale decrement only happens with a nonzero count, so the sum cannot underflow.
    assign w_drop_sum = {1'b0, r_drop_cnt} + CW'(w_orphan_a) + CW'(w_orphan_b) - CW'(w_stale);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid     <= 1'b0;
            r_have_data <= 1'b0;
            r_drop_cnt  <= '0;
            r_buf       <= '0;
            r_pc        <= '0;
            r_dest      <= '0;
            r_rf_we     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_ld_op     <= LD_NONE;
            r_addr_lo   <= '0;
            r_result    <= '0;
            r_ex        <= 1'b0;
        end else begin
            if (w_allowin) begin
                r_valid <= bus.es_to_ms_valid & ~bus.flush;
            end
            if (w_load) begin
                r_pc      <= bus.es_pc;
                r_dest    <= bus.es_dest;
                r_rf_we   <= bus.es_rf_we;
                r_mem_req <= bus.es_mem_req;
                r_ld_op   <= ld_op_e'(bus.es_ld_op);
                r_addr_lo <= bus.es_addr_lo;
                r_result  <= bus.es_result;
                r_ex      <= bus.es_ex;
            end
            if (bus.flush | w_handoff) begin
                r_have_data <= 1'b0;
            end else if (w_capture) begin
                r_have_data <= 1'b1;
            end
            if (w_capture) begin
                r_buf <= bus.data_sram_rdata;
            end
            r_drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    a_drop_cnt_no_overflow: assert property (
        @(posedge clk) disable iff (!resetn) w_drop_sum[CW-1] == 1'b0
    );

    // Bypass live response data so the result is valid in the data_ok cycle itself.
    assign w_ld_data = r_have_data ? r_buf : bus.data_sram_rdata;
    assign w_shifted = w_ld_data >> {r_addr_lo, 3'b000};

    always_comb begin
        w_final = r_result;
        unique case (r_ld_op)
            LD_B:    w_final = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LD_BU:   w_final = {24'h0, w_shifted[7:0]};
            LD_H:    w_final = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LD_HU:   w_final = {16'h0, w_shifted[15:0]};
            LD_W:    w_final = w_ld_data;
            default: w_final = r_result;
        endcase
    end

    assign w_rf_we     = r_rf_we & ~r_ex;
    assign w_fwd_valid = r_valid & w_rf_we & (r_dest != '0);

    assign bus.ms_allowin     = w_allowin;
    assign bus.ms_to_ws_valid = w_to_ws;
    assign bus.ms_pc          = r_pc;
    assign bus.ms_dest        = r_dest;
    assign bus.ms_rf_we       = w_rf_we;
    assign bus.ms_result      = w_final;
    assign bus.ms_ex          = r_ex;
    assign bus.ms_fwd_valid   = w_fwd_valid;
    assign bus.ms_fwd_stall   = w_fwd_valid & r_mem_req & ~r_have_data & ~w_live_ok;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized run
// against a request-ownership reference model.
module tb_mem_stage;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    mem_stage_if bus ();

    mem_stage #(.DROP_CNT_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        we;
        logic [2:0]  op;
        logic [1:0]  lo;
        logic [31:0] res;
        logic        ex;
        logic        req;
        logic        got;
        logic [31:0] data;
    } instr_t;

    function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] d, input logic [31:0] res);
        int unsigned b;
        int unsigned h;
        b = (d >> (8 * lo)) & 32'hFF;
        h = (d >> (16 * lo[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            3'd5:    return d;
            default: return res;
        endcase
    endfunction

    task automatic idle();
        bus.es_to_ms_valid    = 1'b0;
        bus.es_pc             = '0;
        bus.es_dest           = '0;
        bus.es_rf_we          = 1'b0;
        bus.es_mem_req        = 1'b0;
        bus.es_ld_op          = '0;
        bus.es_addr_lo        = '0;
        bus.es_result         = '0;
        bus.es_ex             = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = '0;
        bus.flush             = 1'b0;
        bus.ws_allowin        = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_load(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] pc);
        bus.es_to_ms_valid = 1'b1;
        bus.es_ld_op       = op;
        bus.es_addr_lo     = lo;
        bus.es_mem_req     = 1'b1;
        bus.es_rf_we       = 1'b1;
        bus.es_dest        = 5'd7;
        bus.es_pc          = pc;
    endtask

    task automatic apply_reset();
        idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        #3;
        checks++;
        if (bus.ms_allowin !== 1'b1 || bus.ms_to_ws_valid !== 1'b0 || bus.ms_pc !== 32'h0 ||
            bus.ms_dest !== 5'h0 || bus.ms_rf_we !== 1'b0 || bus.ms_result !== 32'h0 ||
            bus.ms_ex !== 1'b0 || bus.ms_fwd_valid !== 1'b0 || bus.ms_fwd_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got allowin=%0b to_ws=%0b pc=%h dest=%0d we=%0b res=%h ex=%0b fv=%0b fs=%0b exp allowin=1 others=0",
                     bus.ms_allowin, bus.ms_to_ws_valid, bus.ms_pc, bus.ms_dest, bus.ms_rf_we,
                     bus.ms_result, bus.ms_ex, bus.ms_fwd_valid, bus.ms_fwd_stall);
        end
        apply_reset();
    endtask

    task automatic test_ld_b_stall();
        idle();
        send_load(3'b001, 2'b11, 32'h1C00_0100);
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++;
            if (bus.ms_fwd_stall !== 1'b1 || bus.ms_to_ws_valid !== 1'b0) begin
                failures++;
                $display("FAIL ldb_wait%0d got stall=%0b to_ws=%0b exp stall=1 to_ws=0",
                         i, bus.ms_fwd_stall, bus.ms_to_ws_valid);
            end
            step();
        end
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h8000_0000;
        #4;
        checks++;
        if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_result !== 32'hFFFF_FF80 || bus.ms_fwd_stall !== 1'b0 ||
            bus.ms_pc !== 32'h1C00_0100) begin
            failures++;
            $display("FAIL ldb_result got to_ws=%0b res=%h stall=%0b pc=%h exp 1 ffffff80 0 1c000100",
                     bus.ms_to_ws_valid, bus.ms_result, bus.ms_fwd_stall, bus.ms_pc);
        end
        step();
        idle();
        #4;
        checks++;
        if (bus.ms_to_ws_valid !== 1'b0) begin
            failures++;
            $display("FAIL ldb_drained got to_ws=%0b exp 0", bus.ms_to_ws_valid);
        end
        step();
    endtask

    task automatic test_backpressure();
        idle();
        send_load(3'b100, 2'b10, 32'h1C00_0200);
        step();
        idle();
        bus.ws_allowin        = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hBEEF_1234;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++;
            if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b0 || bus.ms_result !== 32'h0000_BEEF) begin
                failures++;
                $display("FAIL ldhu_hold%0d got to_ws=%0b allowin=%0b res=%h exp 1 0 0000beef",
                         i, bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_result);
            end
            step();
            bus.data_sram_data_ok = 1'b0;
            bus.data_sram_rdata   = 32'h5555_AAAA;
        end
        bus.ws_allowin = 1'b1;
        #4;
        checks++;
        if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b1 || bus.ms_result !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL ldhu_release got to_ws=%0b allowin=%0b res=%h exp 1 1 0000beef",
                     bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_result);
        end
        step();
        idle();
    endtask

    task automatic test_flush_drop();
        idle();
        send_load(3'b101, 2'b00, 32'h1C00_0300);
        step();
        idle();
        bus.flush = 1'b1;
        send_load(3'b101, 2'b00, 32'h1C00_0304);
        #4;
        checks++;
        if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allowin !== 1'b1) begin
            failures++;
            $display("FAIL flush_cycle got to_ws=%0b allowin=%0b exp 0 1", bus.ms_to_ws_valid, bus.ms_allowin);
        end
        step();
        idle();
        send_load(3'b101, 2'b00, 32'h1C00_0400);
        step();
        idle();
        for (int i = 1; i <= 2; i++) begin
            bus.data_sram_data_ok = 1'b1;
            bus.data_sram_rdata   = i;
            #4;
            checks++;
            if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_fwd_stall !== 1'b1) begin
                failures++;
                $display("FAIL flush_stale%0d got to_ws=%0b stall=%0b exp 0 1", i, bus.ms_to_ws_valid, bus.ms_fwd_stall);
            end
            step();
        end
        bus.data_sram_rdata = 32'hCAFE_F00D;
        #4;
        checks++;
        if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_result !== 32'hCAFE_F00D || bus.ms_pc !== 32'h1C00_0400) begin
            failures++;
            $display("FAIL flush_live got to_ws=%0b res=%h pc=%h exp 1 cafef00d 1c000400",
                     bus.ms_to_ws_valid, bus.ms_result, bus.ms_pc);
        end
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.es_to_ms_valid = 1'b1;
        bus.es_rf_we       = 1'b1;
        bus.es_dest        = 5'd4;
        bus.es_result      = 32'd5;
        step();
        bus.es_result = 32'd6;
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++;
            if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b1 || bus.ms_fwd_stall !== 1'b0 ||
                bus.ms_result !== 32'(5 + i)) begin
                failures++;
                $display("FAIL b2b_%0d got to_ws=%0b allowin=%0b stall=%0b res=%0d exp 1 1 0 %0d",
                         i, bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_fwd_stall, bus.ms_result, 5 + i);
            end
            step();
            idle();
        end
    endtask

    task automatic test_exception();
        idle();
        bus.es_to_ms_valid = 1'b1;
        bus.es_ex          = 1'b1;
        bus.es_rf_we       = 1'b1;
        bus.es_dest        = 5'd3;
        bus.es_result      = 32'h77;
        step();
        idle();
        #4;
        checks++;
        if (bus.ms_ex !== 1'b1 || bus.ms_rf_we !== 1'b0 || bus.ms_to_ws_valid !== 1'b1 || bus.ms_fwd_valid !== 1'b0) begin
            failures++;
            $display("FAIL exc got ex=%0b we=%0b to_ws=%0b fv=%0b exp 1 0 1 0",
                     bus.ms_ex, bus.ms_rf_we, bus.ms_to_ws_valid, bus.ms_fwd_valid);
        end
        step();
    endtask

    task automatic test_reset_midwait();
        idle();
        send_load(3'b101, 2'b00, 32'h1C00_0500);
        step();
        idle();
        bus.flush = 1'b1;
        step();
        idle();
        send_load(3'b101, 2'b00, 32'h1C00_0504);
        step();
        idle();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allowin !== 1'b1 || bus.ms_pc !== 32'h0 ||
            bus.ms_result !== 32'h0 || bus.ms_fwd_valid !== 1'b0 || bus.ms_fwd_stall !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got to_ws=%0b allowin=%0b pc=%h res=%h fv=%0b fs=%0b exp 0 1 0 0 0 0",
                     bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_pc, bus.ms_result, bus.ms_fwd_valid, bus.ms_fwd_stall);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send_load(3'b101, 2'b00, 32'h1C00_0600);
        step();
        idle();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h1234_5678;
        #4;
        checks++;
        if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_result !== 32'h1234_5678) begin
            failures++;
            $display("FAIL reset_clears_drop got to_ws=%0b res=%h exp 1 12345678", bus.ms_to_ws_valid, bus.ms_result);
        end
        step();
        idle();
    endtask

    // Reference: every issued request is queued with an owner tag; responses retire in order.
    task automatic test_random();
        instr_t      held;
        logic        hv;
        int          q[$];
        int          orphans;
        logic        resp_live;
        logic        avail;
        logic        exp_to_ws;
        logic        exp_allowin;
        logic        exp_fv;
        logic        exp_fs;
        logic [31:0] exp_res;
        int          popped;
        logic        req_in;
        hv   = 1'b0;
        held = '{default: '0};
        idle();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            orphans = 0;
            foreach (q[k]) if (q[k] == 0) orphans++;
            bus.es_to_ms_valid = ($urandom_range(0, 99) < 60);
            bus.es_ex          = ($urandom_range(0, 99) < 10);
            bus.es_ld_op       = (!bus.es_ex && $urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 5)) : 3'd0;
            bus.es_mem_req     = (bus.es_ld_op != 3'd0);
            bus.es_addr_lo     = 2'($urandom_range(0, 3));
            if (bus.es_ld_op == 3'd3 || bus.es_ld_op == 3'd4) bus.es_addr_lo[0] = 1'b0;
            bus.es_pc          = $urandom;
            bus.es_dest        = 5'($urandom_range(0, 31));
            bus.es_rf_we       = 1'($urandom_range(0, 1));
            bus.es_result      = $urandom;
            bus.flush          = (orphans == 0) && ($urandom_range(0, 99) < 6);
            bus.data_sram_data_ok = (q.size() > 0) && ($urandom_range(0, 99) < 40);
            bus.data_sram_rdata   = $urandom;
            bus.ws_allowin        = ($urandom_range(0, 99) < 70);
            #4;
            resp_live   = bus.data_sram_data_ok && (q.size() > 0) && (q[0] == 1);
            avail       = hv && (!held.req || held.got || resp_live);
            exp_to_ws   = avail && !bus.flush;
            exp_allowin = !hv || (avail && bus.ws_allowin) || bus.flush;
            exp_fv      = hv && held.we && !held.ex && (held.dest != 5'd0);
            exp_fs      = exp_fv && held.req && !held.got && !resp_live;
            exp_res     = ref_ext(held.op, held.lo, held.got ? held.data : bus.data_sram_rdata, held.res);
            checks++;
            if (bus.ms_to_ws_valid !== exp_to_ws || bus.ms_allowin !== exp_allowin ||
                bus.ms_fwd_valid !== exp_fv || bus.ms_fwd_stall !== exp_fs) begin
                failures++;
                $display("FAIL rnd_ctrl cyc=%0d got to_ws=%0b allowin=%0b fv=%0b fs=%0b exp %0b %0b %0b %0b",
                         cyc, bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_fwd_valid, bus.ms_fwd_stall,
                         exp_to_ws, exp_allowin, exp_fv, exp_fs);
            end
            if (hv) begin
                checks++;
                if (bus.ms_pc !== held.pc || bus.ms_dest !== held.dest || bus.ms_ex !== held.ex ||
                    bus.ms_rf_we !== (held.we && !held.ex) || (avail && bus.ms_result !== exp_res)) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got pc=%h dest=%0d ex=%0b we=%0b res=%h exp %h %0d %0b %0b %h",
                             cyc, bus.ms_pc, bus.ms_dest, bus.ms_ex, bus.ms_rf_we, bus.ms_result,
                             held.pc, held.dest, held.ex, held.we && !held.ex, exp_res);
                end
            end
            if (bus.data_sram_data_ok) begin
                popped = q.pop_front();
                if (popped == 1 && !bus.flush) begin
                    held.got  = 1'b1;
                    held.data = bus.data_sram_rdata;
                end
            end
            req_in = bus.es_to_ms_valid && bus.es_mem_req;
            if (bus.flush) begin
                foreach (q[k]) q[k] = 0;
                if (req_in) q.push_back(0);
                hv = 1'b0;
            end else begin
                if (exp_to_ws && bus.ws_allowin) hv = 1'b0;
                if (bus.es_to_ms_valid && exp_allowin) begin
                    hv   = 1'b1;
                    held = '{pc: bus.es_pc, dest: bus.es_dest, we: bus.es_rf_we, op: bus.es_ld_op,
                             lo: bus.es_addr_lo, res: bus.es_result, ex: bus.es_ex, req: bus.es_mem_req,
                             got: 1'b0, data: 32'h0};
                    if (req_in) q.push_back(1);
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        idle();
        test_reset();
        test_ld_b_stall();
        test_backpressure();
        test_flush_drop();
        test_back_to_back();
        test_exception();
        test_reset_midwait();
        apply_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
